// File: rtl/axil_cmd_master_pkg.sv
// Shared types for the AXI-Lite command master.
// Holds the FSM state encoding, AXI response codes and the command bundle.
package axil_cmd_master_pkg;

  localparam int CMD_AW = 32;
  localparam int CMD_DW = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD,
    RD_R,
    RSP
  } state_t;

  typedef struct packed {
    logic              write;
    logic [CMD_AW-1:0] addr;
    logic [CMD_DW-1:0] wdata;
    logic [CMD_DW/8-1:0] wstrb;
  } cmd_t;

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle with master and slave views.
// Clock and reset live outside the bundle.
interface axil_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite master behind a valid/ready command port.
// Optional hung-slave watchdog: AXIL_CMD_MASTER_TIMEOUT_EN (adds timeout_o).
module axil_cmd_master
  import axil_cmd_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                    clk_i,
  input  logic                    arstn_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_resp_o,
  output logic                    rsp_write_o,
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  output logic                    timeout_o,
`endif
  axil_if.master                  m_axil
);

  state_t state_q, state_d;
  cmd_t   cmd_q, cmd_d;

  logic cmd_ready_q, cmd_ready_d;
  logic awvalid_q, awvalid_d;
  logic wvalid_q, wvalid_d;
  logic bready_q, bready_d;
  logic arvalid_q, arvalid_d;
  logic rready_q, rready_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_write_q, rsp_write_d;
  logic [1:0] rsp_resp_q, rsp_resp_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d;
  logic busy;
`endif

  // next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          cmd_d.write = cmd_write_i;
          cmd_d.addr  = CMD_AW'(cmd_addr_i);
          cmd_d.wdata = CMD_DW'(cmd_wdata_i);
          cmd_d.wstrb = (CMD_DW/8)'(cmd_wstrb_i);
          cmd_ready_d = 1'b0;
          if (cmd_write_i) begin
            state_d   = WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD;
            arvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        if (awvalid_q && m_axil.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil.wready) wvalid_d = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        if (m_axil.bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = cmd_q.write;
          rsp_resp_d  = m_axil.bresp;
          rsp_rdata_d = '0;
          state_d     = RSP;
        end
      end
      RD: begin
        if (m_axil.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (m_axil.rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = cmd_q.write;
          rsp_resp_d  = m_axil.rresp;
          rsp_rdata_d = m_axil.rdata;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    timeout_d = timeout_q;
    cnt_d     = '0;
    busy      = (state_q != IDLE) && (state_q != RSP);
    if (busy && (state_d == state_q)) begin
      if (cnt_q == CNT_MAX) begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_write_d = cmd_q.write;
        rsp_resp_d  = RESP_DECERR;
        rsp_rdata_d = '0;
        timeout_d   = 1'b1;
        state_d     = RSP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  // state and output registers
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_resp_q  <= '0;
      rsp_rdata_q <= '0;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_resp_o  = rsp_resp_q;
  assign rsp_write_o = rsp_write_q;
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`endif

  assign m_axil.awaddr  = ADDR_WIDTH'(cmd_q.addr);
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = DATA_WIDTH'(cmd_q.wdata);
  assign m_axil.wstrb   = (DATA_WIDTH/8)'(cmd_q.wstrb);
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = ADDR_WIDTH'(cmd_q.addr);
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;

endmodule
